// File: rtl/substitution_equiv_checker.sv
// Exhaustive 6-input equivalence sweeper: drives all 64 vectors into an
// external DUT and compares its delayed response against the golden function
// golden = (a&b) | (c&d&e), with {a,b,c,d,e,f} = vec[5:0] and f ignored.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            request one sweep (ignored unless idle)
//   abort            cancel sweep in progress (wins over start)
//   dut_out          DUT response to vec applied LATENCY cycles earlier
//   vec, vec_valid   stimulus to the DUT
//   busy             sweep in progress (RUN or DRAIN)
//   done             one-cycle completion pulse
//   pass             last completed sweep had no mismatches
//   mismatch_cnt     mismatches seen in last/current sweep (0..64)
//   first_fail       lowest failing vector
//   first_fail_valid first_fail is meaningful
module substitution_equiv_checker #(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic [5:0] vec,
    output logic       vec_valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] mismatch_cnt,
    output logic [5:0] first_fail,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Delay line aligning each issued vector with the DUT response to it.
    logic [5:0]         pipe_vec [LATENCY];
    logic [LATENCY-1:0] pipe_vld;

    logic [2:0] drain_cnt;
    logic [5:0] cmp_vec;
    logic       golden;
    logic       hit;
    logic       go;
    logic       stop;

    assign cmp_vec = pipe_vec[LATENCY-1];
    assign golden  = (cmp_vec[5] & cmp_vec[4])
                   | (cmp_vec[3] & cmp_vec[2] & cmp_vec[1]);
    assign hit     = busy && pipe_vld[LATENCY-1] && (dut_out != golden);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        go        = 1'b0;
        stop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = RUN;
                    go        = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (vec == 6'd63) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (drain_cnt == 3'(LATENCY - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        pipe_vec[0] <= vec;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vec[i] <= pipe_vec[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= vec_valid;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec              <= '0;
            vec_valid        <= 1'b0;
            drain_cnt        <= '0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (go) begin
            vec              <= '0;
            vec_valid        <= 1'b1;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (hit) begin
                mismatch_cnt <= mismatch_cnt + 7'd1;
                if (!first_fail_valid) begin
                    first_fail       <= cmp_vec;
                    first_fail_valid <= 1'b1;
                end
            end
            if (stop) begin
                vec_valid <= 1'b0;
                pass      <= 1'b0;
            end else if (state == RUN) begin
                if (vec == 6'd63) begin
                    vec_valid <= 1'b0;
                    drain_cnt <= '0;
                end else begin
                    vec <= vec + 6'd1;
                end
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
            end
            // The final comparison lands on the same edge that enters DONE.
            if (state == DRAIN && state_nxt == DONE) begin
                pass <= (mismatch_cnt == 7'd0) && !hit;
            end
        end
    end

endmodule

// File: tb/tb_substitution_equiv_checker.sv
// Bench for substitution_equiv_checker: two instances (LATENCY 1 and 3)
// driven by behavioural DUT models, checked per cycle and with literals.
module tb_substitution_equiv_checker;

    logic clk;
    logic rst_n;
    logic start;
    logic abort;

    logic       do1, vv1, b1, dn1, p1, fv1;
    logic [5:0] v1, f1;
    logic [6:0] c1;
    logic       do3, vv3, b3, dn3, p3, fv3;
    logic [5:0] v3, f3;
    logic [6:0] c3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    bit track = 0;
    int m1 = 0;
    int m3 = 0;
    int d3 = 3;
    int e1c, e1f, e3c, e3f;

    logic [5:0] h1 [8];
    logic [5:0] h3 [8];

    substitution_equiv_checker #(.LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_out(do1), .vec(v1), .vec_valid(vv1), .busy(b1), .done(dn1),
        .pass(p1), .mismatch_cnt(c1), .first_fail(f1),
        .first_fail_valid(fv1)
    );

    substitution_equiv_checker #(.LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_out(do3), .vec(v3), .vec_valid(vv3), .busy(b3), .done(dn3),
        .pass(p3), .mismatch_cnt(c3), .first_fail(f3),
        .first_fail_valid(fv3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit gold(logic [5:0] v);
        return (v[5] & v[4]) | (v[3] & v[2] & v[1]);
    endfunction

    // 0 = golden, 1 = a&b only, 2 = stuck-at-0, 3 = stuck-at-1
    function automatic bit resp(int mode, logic [5:0] v);
        case (mode)
            1: return v[5] & v[4];
            2: return 1'b0;
            3: return 1'b1;
            default: return gold(v);
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin
            h1[i] = '0;
            h3[i] = '0;
        end
    end

    always @(posedge clk) begin
        h1[0] <= v1;
        h3[0] <= v3;
        for (int i = 1; i < 8; i++) begin
            h1[i] <= h1[i-1];
            h3[i] <= h3[i-1];
        end
    end

    always_comb begin
        do1 = resp(m1, h1[0]);
        do3 = resp(m3, h3[d3-1]);
    end

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    // Vector k is answered by a DUT of delay D that saw vec(T+1+k+L-D);
    // the sweep shows min(j,63) in cycle T+1+j.
    task automatic calc(input int L, input int D, input int mode,
                        output int c, output int f);
        c = 0;
        f = 0;
        for (int k = 0; k < 64; k++) begin
            int v;
            v = k + L - D;
            if (v > 63) v = 63;
            if (resp(mode, 6'(v)) != gold(6'(k))) begin
                if (c == 0) f = k;
                c++;
            end
        end
    endtask

    task automatic chk_inst(string n, int L, int o, logic [5:0] v,
                            logic vv, logic b, logic dn, logic p,
                            logic [6:0] c, logic [5:0] f, logic fv,
                            int ec, int ef);
        chk({n, ".vec_valid"}, int'(vv), int'(o <= 64));
        if (o <= 64) chk({n, ".vec"}, int'(v), o - 1);
        chk({n, ".busy"}, int'(b), int'(o <= 64 + L));
        chk({n, ".done"}, int'(dn), int'(o == 65 + L));
        if (o >= 65 + L) begin
            chk({n, ".pass"}, int'(p), int'(ec == 0));
            chk({n, ".mismatch_cnt"}, int'(c), ec);
            chk({n, ".first_fail_valid"}, int'(fv), int'(ec != 0));
            if (ec != 0) chk({n, ".first_fail"}, int'(f), ef);
        end
    endtask

    always @(negedge clk) begin
        if (track) begin
            int o;
            o = cyc - t0;
            if (o >= 1 && o <= 72) begin
                chk_inst("u1", 1, o, v1, vv1, b1, dn1, p1, c1, f1, fv1,
                         e1c, e1f);
                chk_inst("u3", 3, o, v3, vv3, b3, dn3, p3, c3, f3, fv3,
                         e3c, e3f);
            end
        end
    end

    task automatic sweep(input int extra);
        calc(1, 1, m1, e1c, e1f);
        calc(3, d3, m3, e3c, e3f);
        start = 1;
        t0 = cyc;
        track = 1;
        @(negedge clk);
        start = 0;
        while (cyc < t0 + 72) begin
            @(negedge clk);
            start = (extra > 0 && cyc == t0 + extra);
        end
        start = 0;
        track = 0;
        @(negedge clk);
    endtask

    task automatic chk_zero(string n);
        chk({n, ".vec"}, int'(v1), 0);
        chk({n, ".vec_valid"}, int'(vv1), 0);
        chk({n, ".busy"}, int'(b1), 0);
        chk({n, ".done"}, int'(dn1), 0);
        chk({n, ".pass"}, int'(p1), 0);
        chk({n, ".cnt"}, int'(c1), 0);
        chk({n, ".ff"}, int'(f1), 0);
        chk({n, ".ffv"}, int'(fv1), 0);
        chk({n, ".busy3"}, int'(b3), 0);
        chk({n, ".vv3"}, int'(vv3), 0);
        chk({n, ".cnt3"}, int'(c3), 0);
    endtask

    initial begin
        int t;
        int ndone;
        rst_n = 0;
        start = 0;
        abort = 0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1;
        @(negedge clk);
        chk_zero("idle");

        // Both golden; extra start lands in u1's DONE cycle.
        m1 = 0; m3 = 0; d3 = 3;
        sweep(66);
        chk("A.pass1", int'(p1), 1);
        chk("A.cnt1", int'(c1), 0);
        chk("A.ffv1", int'(fv1), 0);
        chk("A.pass3", int'(p3), 1);

        // a&b only; LATENCY 3 with a 2-cycle DUT.
        m1 = 1; m3 = 0; d3 = 2;
        sweep(0);
        chk("B.cnt1", int'(c1), 6);
        chk("B.ff1", int'(f1), 14);
        chk("B.ffv1", int'(fv1), 1);
        chk("B.pass1", int'(p1), 0);
        chk("B.pass3", int'(p3), 0);
        repeat (5) @(negedge clk);
        chk("B.hold_cnt1", int'(c1), 6);
        chk("B.hold_ff1", int'(f1), 14);

        // Stuck-at-0 and stuck-at-1.
        m1 = 2; m3 = 3; d3 = 3;
        sweep(0);
        chk("C.cnt1", int'(c1), 22);
        chk("C.ff1", int'(f1), 14);
        chk("C.cnt3", int'(c3), 42);
        chk("C.ff3", int'(f3), 0);
        chk("C.ffv3", int'(fv3), 1);

        // Restart attempt mid-sweep is ignored.
        m1 = 0; m3 = 0; d3 = 3;
        sweep(10);
        chk("E.pass1", int'(p1), 1);

        // start+abort together while idle.
        start = 1; abort = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("SA.busy1", int'(b1), 0);
        chk("SA.busy3", int'(b3), 0);
        chk("SA.vv1", int'(vv1), 0);
        @(negedge clk);
        chk("SA.busy1b", int'(b1), 0);

        // Abort at T+20.
        m1 = 2; m3 = 0;
        start = 1;
        t = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < t + 20) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("F.busy1", int'(b1), 0);
        chk("F.busy3", int'(b3), 0);
        chk("F.vv1", int'(vv1), 0);
        chk("F.pass1", int'(p1), 0);
        chk("F.cnt1", int'(c1), 2);
        chk("F.ff1", int'(f1), 14);
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (dn1 || dn3) ndone++;
        end
        chk("F.no_done", ndone, 0);
        chk("F.pass_hold", int'(p1), 0);

        // Reset mid-sweep at T+30, then a full sweep.
        m1 = 2; m3 = 0;
        start = 1;
        t = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < t + 30) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk_zero("G.rst");
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (dn1 || dn3) ndone++;
        end
        chk("G.no_done", ndone, 0);
        sweep(0);
        chk("G.cnt1", int'(c1), 22);
        chk("G.pass3", int'(p3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
